mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle controller plus shift-add datapath that adds RV32M MUL and MULHU to the pipeline's EX stage.
- Decodes the instruction in EX and stalls the pipeline while an iterative radix-2 multiplier runs, then presents the result for one cycle.
- Sits beside the ALU; the EX result mux selects mul_result when mul_done=1.

Parameters:
DATA_W, 32, operand/result width; iteration count = DATA_W

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX stage holds a valid instruction
opcode  input  7  EX instruction opcode
funct3  input  3  EX instruction funct3
funct7  input  7  EX instruction funct7
op_a  input  DATA_W  rs1 operand (multiplicand)
op_b  input  DATA_W  rs2 operand (multiplier)
flush  input  1  EX stage squashed (branch/jump redirect)
stall  output  1  freeze PC, IF/ID, ID/EX (combinational)
mul_done  output  1  mul_result valid this cycle
mul_result  output  DATA_W  product word (registered)

Behaviour:
- start = ex_valid & opcode==0110011 & funct7==0000001 & (funct3==000 | funct3==011) & !flush. Other funct3 with funct7=0000001 (DIV/REM/MULH/MULHSU) is not started: no stall, no action.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = start, mul_done = 0.
  - On start: acc <= 0, mcand <= zero-extended op_a (2*DATA_W bits), mplier <= op_b, cnt <= 0, sel_hi <= (funct3==011), go BUSY.
- BUSY:
  - stall = 1, mul_done = 0.
  - Each cycle: if mplier[0], acc <= acc + mcand (2*DATA_W wide, no overflow possible); mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt==DATA_W-1 (final iteration this cycle), go DONE.
  - flush=1 in BUSY aborts: acc is discarded, go IDLE, mul_result unchanged.
- DONE:
  - stall = 0, mul_done = 1; pipeline advances at the end of this cycle.
  - Next state is always IDLE, so the same instruction cannot re-trigger.
  - flush in DONE is ignored; the instruction leaves EX anyway.
- mul_result:
  - Loaded on the BUSY->DONE transition: sel_hi ? acc_final[2*DATA_W-1:DATA_W] : acc_final[DATA_W-1:0], where acc_final includes the last iteration.
  - Holds until the next load.
- Latency: start seen in cycle T0 (IDLE, stall=1); BUSY T1..T_DATA_W; DONE at T_(DATA_W+1). stall is high for DATA_W+1 cycles.
- Back-to-back: a MUL entering EX after DONE is seen in IDLE the next cycle and starts normally (one non-stall cycle between).
- Reset: state=IDLE, cnt=0, acc/mcand/mplier=0, mul_result=0, sel_hi=0. Outputs: stall=0 (given ex_valid=0), mul_done=0. Reset mid-BUSY abandons the operation and no mul_done follows.
- Operands are sampled only at start; op_a/op_b changes during BUSY have no effect.

Decomposition:
- Shared package:
  - OPC_ALU_R=0110011, F7_MULDIV=0000001, F3_MUL=000, F3_MULHU=011
  - State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - Counter width = $clog2(DATA_W)
- One sub-module, mul_shift_add_dp:
  - Holds acc, mcand, mplier.
  - Controls: load, step.
  - Output: acc_next.
- FSM, decode and counter stay in mul_sequencer.

Test Plan:
- MUL 7*6 (funct3=000): stall=1 for 33 cycles from T0, mul_done=1 at T33 with mul_result=0x0000002A, stall=0 at T33.
- MULHU 0xFFFFFFFF*0xFFFFFFFF: mul_result=0xFFFFFFFE at DONE. Same operands with MUL: 0x00000001.
- ADD (funct7=0000000) and DIV (funct7=0000001, funct3=100), ex_valid=1: stall and mul_done stay 0 for 40 cycles.
- MUL 3*5 with flush=1 at BUSY cycle 10: stall=0 the following cycle, no mul_done, mul_result keeps its prior value.
- rst=1 at BUSY cycle 5: next cycle state IDLE, stall=0 (ex_valid=0), mul_result=0. A fresh MUL 2*2 afterwards yields 0x4 after full latency.
- Two consecutive MULs, 0x10000*0x10000 then 0x12345678*0x2: results 0x00000000 then 0x2468ACF0. Second start occurs exactly one cycle after the first DONE.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// rtl/mul_sequencer_pkg.sv - decode constants, state encoding and sizing helper for mul_sequencer
package mul_sequencer_pkg;

    localparam logic [6:0] OPC_ALU_R = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; a single-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - radix-2 shift-add multiplier datapath (acc, mcand, mplier)
module mul_shift_add_dp #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;

    // Accumulator is double width, so the partial-product sum can never overflow.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, op_a};
            mplier <= op_b;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - EX-stage MUL/MULHU decode, stall control and iteration sequencing
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              stall,
    output logic              mul_done,
    output logic [DATA_W-1:0] mul_result
);

    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic                sel_hi;
    logic                start;
    logic                last;
    logic                load;
    logic                step;
    logic [2*DATA_W-1:0] acc_next;

    assign start = ex_valid && (opcode == OPC_ALU_R) && (funct7 == F7_MULDIV)
                && ((funct3 == F3_MUL) || (funct3 == F3_MULHU)) && !flush;
    assign last  = (cnt == CNT_LAST);

    mul_shift_add_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .op_a     (op_a),
        .op_b     (op_b),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mul_done   = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // A redirect squashes the multiply; the partial product is simply dropped.
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                mul_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_hi     <= 1'b0;
            mul_result <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                cnt    <= '0;
                sel_hi <= (funct3 == F3_MULHU);
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (step && last) begin
                mul_result <= sel_hi ? acc_next[2*DATA_W-1:DATA_W] : acc_next[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed self-checking bench for mul_sequencer with a result scoreboard
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        mul_done;
    logic [31:0] mul_result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];

    mul_sequencer #(
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .stall      (stall),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a multiply, holds it while stalled, and compares against the scoreboard at mul_done.
    task automatic do_mul(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          stall_cyc;
        bit          seen;
        @(negedge clk);
        ex_valid = 1'b1; opcode = OPC_ALU_R; funct7 = F7_MULDIV; funct3 = f3;
        op_a = a; op_b = b; flush = 1'b0;
        p = {32'd0, a} * {32'd0, b};
        sb.push_back((f3 == F3_MULHU) ? p[63:32] : p[31:0]);
        #1;
        check({tag, "_t0_stall"}, {31'd0, stall}, 32'd1);
        check({tag, "_t0_done"}, {31'd0, mul_done}, 32'd0);
        stall_cyc = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            op_a = $urandom;
            op_b = $urandom;
            #1;
            if (mul_done) seen = 1'b1;
            else if (stall) stall_cyc++;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
            check({tag, "_stall_cycles"}, stall_cyc, 32'd33);
            check({tag, "_result"}, mul_result, sb.pop_front());
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic no_start(input string tag, input logic [6:0] f7, input logic [2:0] f3);
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ex_valid = 1'b1; opcode = OPC_ALU_R; funct7 = f7; funct3 = f3;
            op_a = $urandom; op_b = $urandom; flush = 1'b0;
            #1;
            if (stall || mul_done) bad++;
        end
        check({tag, "_no_stall_or_done"}, bad, 32'd0);
    endtask

    task automatic go_idle();
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (mul_done) dones++;
        end
        check({tag, "_no_done"}, dones, 32'd0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        op_a = '0; op_b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_done", {31'd0, mul_done}, 32'd0);
        check("reset_result", mul_result, 32'd0);
        rst = 1'b0;

        do_mul("mul_7x6", F3_MUL, 32'd7, 32'd6);
        go_idle();
        do_mul("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        go_idle();
        do_mul("mul_ff", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        go_idle();

        no_start("add", 7'b0000000, 3'b000);
        no_start("div", F7_MULDIV, 3'b100);
        go_idle();

        // Flush in the tenth BUSY cycle of MUL 3*5.
        @(negedge clk);
        ex_valid = 1'b1; opcode = OPC_ALU_R; funct7 = F7_MULDIV; funct3 = F3_MUL;
        op_a = 32'd3; op_b = 32'd5; flush = 1'b0;
        #1;
        check("flush_t0_stall", {31'd0, stall}, 32'd1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_next_stall", {31'd0, stall}, 32'd0);
        watch_no_done("flush", 40);
        check("flush_result_held", mul_result, 32'd1);

        // Reset in the fifth BUSY cycle of MUL 9*9.
        @(negedge clk);
        ex_valid = 1'b1; opcode = OPC_ALU_R; funct7 = F7_MULDIV; funct3 = F3_MUL;
        op_a = 32'd9; op_b = 32'd9;
        repeat (5) @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy_stall", {31'd0, stall}, 32'd0);
        check("rst_busy_done", {31'd0, mul_done}, 32'd0);
        check("rst_busy_result", mul_result, 32'd0);
        watch_no_done("rst_busy", 40);
        do_mul("mul_2x2", F3_MUL, 32'd2, 32'd2);
        go_idle();

        // Back-to-back: second start lands in the IDLE cycle right after DONE.
        do_mul("b2b_first", F3_MUL, 32'h0001_0000, 32'h0001_0000);
        do_mul("b2b_second", F3_MUL, 32'h1234_5678, 32'h0000_0002);
        go_idle();

        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
